// File: rtl/pe2_result_collector.sv
// -----------------------------------------------------------------------------
// pe2_result_collector
//
// Output-side companion to the PE2 butterfly. Every op issued to PE2 leaves a
// tag {sel, idx} in a tag shift register. When the tag reaches the tap that
// matches its mode latency, PE2's bf_upper/bf_lower are captured together with
// the tag into a first-word fall-through FIFO for the downstream memory writer.
// Credit-based backpressure on in_ready guarantees that every in-flight op
// already owns a FIFO slot. Mode changes stall the issuer until the pipeline
// drains, so NTT and INTT results can never land in the same cycle.
//
// Optional feature: define PE2_COLLECT_CHECK_EN to carry expected results
// (exp_upper/exp_lower) with each tag and count capture-time mismatches.
//
// Parameters:
//   DATA_WIDTH  coefficient width
//   NTT_LAT     PE2 latency for sel=0
//   INTT_LAT    PE2 latency for sel=1, must be >= NTT_LAT
//   FIFO_DEPTH  result FIFO entries, power of two, >= 2
//   IDX_WIDTH   issue-index width (wraps at 2^IDX_WIDTH)
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid, in_sel    op presented to PE2 this cycle and its mode
//   in_ready            issue permitted; an issue is in_valid & in_ready
//   pe_upper, pe_lower  PE2 bf_upper / bf_lower
//   exp_upper/lower     (check build only) expected results, sampled at issue
//   mismatch_cnt        (check build only) saturating mismatch count
//   mismatch            (check build only) 1-cycle pulse on a bad capture
//   out_valid/ready     FIFO head handshake
//   out_upper/lower     captured results at the FIFO head
//   out_idx, out_sel    issue index and mode of the FIFO head
//   inflight            ops issued but not yet captured
// -----------------------------------------------------------------------------
module pe2_result_collector #(
  parameter int DATA_WIDTH = 12,
  parameter int NTT_LAT    = 8,
  parameter int INTT_LAT   = 14,
  parameter int FIFO_DEPTH = 8,
  parameter int IDX_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sel,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] pe_upper,
  input  logic [DATA_WIDTH-1:0] pe_lower,
`ifdef PE2_COLLECT_CHECK_EN
  input  logic [DATA_WIDTH-1:0] exp_upper,
  input  logic [DATA_WIDTH-1:0] exp_lower,
  output logic [IDX_WIDTH-1:0]  mismatch_cnt,
  output logic                  mismatch,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_upper,
  output logic [DATA_WIDTH-1:0] out_lower,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic                  out_sel,
  output logic [4:0]            inflight
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam int NTT_TAP  = NTT_LAT - 1;
  localparam int INTT_TAP = INTT_LAT - 1;

  typedef struct packed {
    logic                  vld;
    logic                  sel;
    logic [IDX_WIDTH-1:0]  idx;
`ifdef PE2_COLLECT_CHECK_EN
    logic [DATA_WIDTH-1:0] exp_up;
    logic [DATA_WIDTH-1:0] exp_lo;
`endif
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] upper;
    logic [DATA_WIDTH-1:0] lower;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  sel;
  } entry_t;

  tag_t                 tags [INTT_LAT];
  tag_t                 new_tag;
  entry_t               mem [FIFO_DEPTH];
  entry_t               head;
  logic [IDX_WIDTH-1:0] issue_idx;
  logic                 mode_q;     // mode of the ops currently in flight
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        fifo_cnt;
  logic                 fire, pop, push, fifo_full, mode_ok, credit_ok;
  logic                 cap_ntt, cap_intt, capture, cap_sel;
  logic [IDX_WIDTH-1:0] cap_idx;

  // ---------------------------------------------------------------- issue side
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & out_ready;
  assign fifo_full = (fifo_cnt == DEPTH_C);

  // Mixing modes in flight could make an INTT capture collide with a later
  // NTT capture, so a mode change waits for an empty pipeline.
  assign mode_ok   = (inflight == '0) || (in_sel == mode_q);
  // free = DEPTH - cnt + pop must exceed inflight; rearranged to stay unsigned.
  assign credit_ok = (32'(DEPTH_C) + 32'(pop)) > (32'(fifo_cnt) + 32'(inflight));
  assign in_ready  = rst & mode_ok & credit_ok;
  assign fire      = in_valid & in_ready;

  // NOTE: always_comb assigns every output first, so no path can infer a latch.
  always_comb begin
    new_tag     = '0;
    new_tag.vld = fire;
    new_tag.sel = in_sel;
    new_tag.idx = issue_idx;
`ifdef PE2_COLLECT_CHECK_EN
    new_tag.exp_up = exp_upper;
    new_tag.exp_lo = exp_lower;
`endif
  end

  // -------------------------------------------------------------- capture side
  assign cap_ntt  = tags[NTT_TAP].vld  & ~tags[NTT_TAP].sel;
  assign cap_intt = tags[INTT_TAP].vld &  tags[INTT_TAP].sel;
  assign capture  = cap_ntt | cap_intt;
  assign cap_sel  = cap_ntt ? tags[NTT_TAP].sel : tags[INTT_TAP].sel;
  assign cap_idx  = cap_ntt ? tags[NTT_TAP].idx : tags[INTT_TAP].idx;
  // A push on full without a pop would violate the credit invariant; it is
  // refused here and flagged by the assertion below.
  assign push     = capture & (~fifo_full | pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < INTT_LAT; i++) tags[i] <= '0;
      issue_idx <= '0;
      mode_q    <= 1'b0;
      inflight  <= '0;
    end else begin
      tags[0] <= new_tag;
      for (int i = 1; i < INTT_LAT; i++) begin
        tags[i] <= tags[i-1];
        // An NTT tag retires at its tap; INTT tags pass through untouched.
        if (i == NTT_LAT && cap_ntt) tags[i].vld <= 1'b0;
      end
      if (fire) begin
        issue_idx <= issue_idx + 1'b1;
        mode_q    <= in_sel;
      end
      case ({fire, capture})
        2'b10:   inflight <= inflight + 5'd1;
        2'b01:   inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // ---------------------------------------------------------------------- FIFO
  // NOTE: FIFO storage has no reset; out_* are gated by out_valid so stale
  // contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{upper: pe_upper, lower: pe_lower,
                               idx: cap_idx, sel: cap_sel};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_upper = out_valid ? head.upper : '0;
  assign out_lower = out_valid ? head.lower : '0;
  assign out_idx   = out_valid ? head.idx   : '0;
  assign out_sel   = out_valid & head.sel;

  push_never_full: assert property (@(posedge clk) disable iff (!rst)
                                    !(capture && fifo_full && !pop));

`ifdef PE2_COLLECT_CHECK_EN
  // ------------------------------------------------------- optional checking
  logic cap_bad;
  assign cap_bad = cap_ntt
    ? (pe_upper != tags[NTT_TAP].exp_up)  || (pe_lower != tags[NTT_TAP].exp_lo)
    : (pe_upper != tags[INTT_TAP].exp_up) || (pe_lower != tags[INTT_TAP].exp_lo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      mismatch <= capture & cap_bad;
      if (capture && cap_bad && (mismatch_cnt != '1))
        mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe2_result_collector.sv
// -----------------------------------------------------------------------------
// tb_pe2_result_collector
//
// Directed bench for pe2_result_collector (IDX_WIDTH=4 so index wrap is
// reachable). A negedge monitor models PE2 as a latency-accurate butterfly,
// pushes the expected {upper, lower, idx, sel} at every issue and pops/compares
// at every FIFO handshake. Cycles without a scheduled PE2 result present junk
// on pe_upper/pe_lower so a mis-timed capture is visible.
// -----------------------------------------------------------------------------
module tb_pe2_result_collector;
  localparam int DW = 12;
  localparam int NL = 8;
  localparam int IL = 14;
  localparam int FD = 8;
  localparam int IW = 4;
  localparam int Q  = 3329;

  logic          clk = 1'b0, rst = 1'b0;
  logic          in_valid = 1'b0, in_sel = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] pe_upper = '0, pe_lower = '0;
  logic          in_ready, out_valid, out_sel;
  logic [DW-1:0] out_upper, out_lower;
  logic [IW-1:0] out_idx;
  logic [4:0]    inflight;
`ifdef PE2_COLLECT_CHECK_EN
  logic [DW-1:0] exp_upper = '0, exp_lower = '0;
  logic [IW-1:0] mismatch_cnt;
  logic          mismatch;
`endif

  pe2_result_collector #(
    .DATA_WIDTH(DW), .NTT_LAT(NL), .INTT_LAT(IL), .FIFO_DEPTH(FD), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready),
    .pe_upper(pe_upper), .pe_lower(pe_lower),
`ifdef PE2_COLLECT_CHECK_EN
    .exp_upper(exp_upper), .exp_lower(exp_lower),
    .mismatch_cnt(mismatch_cnt), .mismatch(mismatch),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_upper(out_upper), .out_lower(out_lower),
    .out_idx(out_idx), .out_sel(out_sel), .inflight(inflight)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] up;
    logic [DW-1:0] lo;
    logic [IW-1:0] idx;
    logic          sel;
  } res_t;

  res_t            exp_q[$];
  logic [2*DW-1:0] sched [int];     // PE2 output keyed by the edge it is due on
  int              n_cmp = 0, n_err = 0;
  int              fires = 0, last_fire_edge = 0;
  logic [IW-1:0]   tb_idx = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural PE2: CT butterfly for NTT, GS butterfly for INTT, mod q.
  function automatic logic [2*DW-1:0] pe2_model(input int u, input int v,
                                               input int w1, input int w2,
                                               input logic sel);
    int up, lo, t;
    if (!sel) begin
      t  = (v * w1) % Q;
      up = (u + t) % Q;
      lo = (u + Q - t) % Q;
    end else begin
      up = (u + v) % Q;
      lo = ((u + Q - v) * w2) % Q;
    end
    return {up[DW-1:0], lo[DW-1:0]};
  endfunction

  // Monitor / PE2 model / scoreboard, evaluated mid-cycle.
  initial begin
    int          e, lat;
    int          u, v, w1, w2;
    logic [2*DW-1:0] res;
    res_t        r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        sched.delete();
        tb_idx = '0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 32'(0));
          end else begin
            r = exp_q.pop_front();
            check("out_upper", 32'(out_upper), 32'(r.up));
            check("out_lower", 32'(out_lower), 32'(r.lo));
            check("out_idx",   32'(out_idx),   32'(r.idx));
            check("out_sel",   32'(out_sel),   32'(r.sel));
          end
        end
        e = cyc + 1;  // the edge that follows this negedge
        if (sched.exists(e)) begin
          {pe_upper, pe_lower} = sched[e];
          sched.delete(e);
        end else begin
          pe_upper = 12'hE00 | 12'(cyc[7:0]);
          pe_lower = 12'hD00 | 12'(cyc[7:0]);
        end
        if (in_valid && in_ready) begin
          u  = (fires * 7 + 1) % Q;
          v  = (fires * 11 + 2) % Q;
          w1 = (fires * 13 + 3) % Q;
          w2 = (fires * 5 + 4) % Q;
          res = pe2_model(u, v, w1, w2, in_sel);
          lat = in_sel ? IL : NL;
          sched[e + lat] = res;
          exp_q.push_back('{up: res[2*DW-1:DW], lo: res[DW-1:0], idx: tb_idx, sel: in_sel});
`ifdef PE2_COLLECT_CHECK_EN
          exp_upper = res[2*DW-1:DW];
          exp_lower = res[DW-1:0];
`endif
          tb_idx++;
          fires++;
          last_fire_edge = e;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic issue(input int n, input logic sel);
    int target, budget;
    target = fires + n;
    budget = 300;
    in_sel = sel;
    in_valid = 1'b1;
    while (fires < target && budget > 0) begin
      tick();
      budget--;
    end
    in_valid = 1'b0;
    check("issue_in_time", 32'(budget > 0), 32'(1));
  endtask

  task automatic wait_out(output int lat);
    int budget;
    budget = 100;
    while (!out_valid && budget > 0) begin
      tick();
      budget--;
    end
    check("output_in_time", 32'(budget > 0), 32'(1));
    lat = cyc - last_fire_edge;
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while ((exp_q.size() != 0 || out_valid || inflight != 0) && budget > 0) begin
      tick();
      budget--;
    end
    check("drain_in_time", 32'(budget > 0), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ntt_last, base, bad;

    // Reset state.
    tick();
    check("rst_in_ready",  32'(in_ready),  32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_inflight",  32'(inflight),  32'(0));
    check("rst_out_idx",   32'(out_idx),   32'(0));
    check("rst_out_upper", 32'(out_upper), 32'(0));
    rst = 1'b1;
    out_ready = 1'b1;

    // Single NTT: u/v/w1/w2 = 1/2/3/4, idx 0, capture 8 edges after issue.
    issue(1, 1'b0);
    check("ntt_inflight_1", 32'(inflight), 32'(1));
    wait_out(lat);
    check("ntt_latency", 32'(lat), 32'(NL));
    check("ntt_idx", 32'(out_idx), 32'(0));
    check("ntt_sel", 32'(out_sel), 32'(0));
    drain();
    check("ntt_inflight_0", 32'(inflight), 32'(0));

    // Single INTT at idx 5, capture 14 edges after issue and not earlier.
    issue(4, 1'b0);
    drain();
    issue(1, 1'b1);
    wait_out(lat);
    check("intt_latency", 32'(lat), 32'(IL));
    check("intt_idx", 32'(out_idx), 32'(5));
    check("intt_sel", 32'(out_sel), 32'(1));
    drain();

    // Mode switch: 3 NTT then INTT; INTT waits for the pipeline to drain.
    do_reset();
    issue(3, 1'b0);
    ntt_last = last_fire_edge;
    in_sel = 1'b1;
    in_valid = 1'b1;
    #1;
    check("mode_stall_ready", 32'(in_ready), 32'(0));
    bad = 0;
    base = fires;
    for (int i = 0; i < 40 && fires == base; i++) begin
      if (inflight != 0 && in_ready) bad++;
      tick();
    end
    in_valid = 1'b0;
    check("mode_no_early_ready", 32'(bad), 32'(0));
    check("mode_intt_fire_edge", 32'(last_fire_edge - ntt_last), 32'(NL + 1));
    drain();

    // Backpressure: only FIFO_DEPTH ops accepted while the sink is stalled.
    do_reset();
    out_ready = 1'b0;
    in_sel = 1'b0;
    in_valid = 1'b1;
    base = fires;
    repeat (40) tick();
    check("bp_fires", 32'(fires - base), 32'(FD));
    check("bp_in_ready", 32'(in_ready), 32'(0));
    check("bp_inflight", 32'(inflight), 32'(0));
    check("bp_head_idx", 32'(out_idx), 32'(0));
    out_ready = 1'b1;
    issue(12, 1'b0);
    drain();

    // Index wrap: 17 issues give idx 0..15, 0.
    do_reset();
    issue(17, 1'b0);
    drain();

    // Reset with 4 INTT in flight: everything discarded, idx restarts at 0.
    do_reset();
    issue(4, 1'b1);
    check("rf_inflight_4", 32'(inflight), 32'(4));
    repeat (3) tick();
    do_reset();
    check("rf_out_valid", 32'(out_valid), 32'(0));
    check("rf_inflight_0", 32'(inflight), 32'(0));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) bad++;
      tick();
    end
    check("rf_no_stale", 32'(bad), 32'(0));
    issue(1, 1'b0);
    wait_out(lat);
    check("rf_first_idx", 32'(out_idx), 32'(0));
    drain();

`ifdef PE2_COLLECT_CHECK_EN
    check("mismatch_cnt", 32'(mismatch_cnt), 32'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe2_result_collector.md
Name: pe2_result_collector

Overview:
- Output-side companion to the PE2 butterfly: the stimulus side issues (u, v, w1, w2, sel) to PE2; this block captures PE2's bf_upper/bf_lower at the correct pipeline depth.
- Tags each capture with an issue index and mode, and buffers it in a ready/valid FIFO for the downstream memory writer.
- Applies credit-based backpressure to the issuer, so no PE2 result is ever dropped or mis-aligned across NTT/INTT mode changes.

Parameters:
- DATA_WIDTH, 12, coefficient width (q = 3329)
- NTT_LAT, 8, PE2 latency with sel=0
- INTT_LAT, 14, PE2 latency with sel=1; must be >= NTT_LAT
- FIFO_DEPTH, 8, result FIFO entries; power of two, >= 2
- IDX_WIDTH, 16, issue-index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  op presented to PE2 this cycle
- in_sel  in  1  mode of presented op: 0=NTT, 1=INTT
- in_ready  out  1  issue permitted; issue occurs only when in_valid & in_ready
- pe_upper  in  DATA_WIDTH  PE2 bf_upper
- pe_lower  in  DATA_WIDTH  PE2 bf_lower
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_upper  out  DATA_WIDTH  captured upper
- out_lower  out  DATA_WIDTH  captured lower
- out_idx  out  IDX_WIDTH  issue index of head
- out_sel  out  1  mode of head
- inflight  out  5  ops issued, not yet captured

Behaviour:
- Reset (rst low, async):
  - Clears the tag shift register, FIFO pointers, issue counter and inflight; all outputs are 0, including in_ready.
  - The first issue is possible in the cycle after rst deasserts.
  - Reset mid-operation discards all in-flight tags and buffered results. PE2 outputs arriving afterwards are ignored because their tags are gone.
- Issue: fire = in_valid & in_ready at edge k. This pushes tag {sel, idx} into stage 0 of an INTT_LAT-deep tag shift register, then idx increments and wraps at 2^IDX_WIDTH.
- Capture:
  - An NTT tag is taken from tap NTT_LAT; an INTT tag from tap INTT_LAT.
  - At edge k+LAT the block writes {pe_upper, pe_lower, idx, sel} into the FIFO.
  - The tag leaves the shift register at its tap; it is not captured twice.
- Mode ordering: at most one capture per cycle.
  - in_ready = 0 when in_sel differs from the mode of any in-flight op, i.e. the issuer stalls until the pipeline drains.
  - Same-mode back-to-back issue is allowed every cycle.
- Credit:
  - in_ready = 1 only if FIFO free entries > inflight, counting a same-cycle FIFO pop as freeing an entry.
  - This guarantees a FIFO push never hits full. Any push on full is a design error and drops nothing silently: assert in simulation.
- inflight: +1 on fire, -1 on capture; unchanged when both occur in the same cycle.
- FIFO:
  - First-word fall-through; out_* reflect the head whenever out_valid = 1.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop at full or empty is legal and keeps the count. Push into an empty FIFO gives out_valid = 1 on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Arithmetic: none on data. Values pass through bit-exact; no reduction mod q.

Optional Feature:
- Macro PE2_COLLECT_CHECK_EN.
- When defined:
  - Adds inputs exp_upper and exp_lower (DATA_WIDTH each), sampled at issue and carried with the tag.
  - At capture, the block compares them with pe_upper/pe_lower.
  - Adds outputs mismatch_cnt (IDX_WIDTH, saturating) and mismatch (1-cycle pulse on the capture edge); both reset to 0.
- When undefined: ports absent, no compare logic; the rest of the behaviour is identical.

Test Plan:
- Single NTT: issue u/v/w1/w2=0x001/0x002/0x003/0x004 with sel=0 at cycle 0, idx=0 -> capture at cycle 8; out_upper/out_lower equal PE2 outputs, out_idx=0, out_sel=0, inflight returns to 0.
- Single INTT: sel=1, idx=5 -> capture at cycle 14, out_sel=1, out_idx=5; no capture at cycle 8.
- Backpressure: out_ready=0, 20 consecutive NTT issues -> in_ready drops after 8 fires (FIFO_DEPTH); raising out_ready drains idx 0..7 in order, then issue resumes, no loss.
- Mode switch: 3 NTT issues, then INTT presented -> in_ready=0 until inflight=0, then INTT accepted; output order idx 0,1,2,3.
- Reset mid-flight: 4 INTT in flight, rst low for 1 cycle -> out_valid=0, inflight=0, next issue gets idx=0, no stale captures.
- Index wrap with IDX_WIDTH=4: 17 issues -> out_idx sequence 0..15, 0.
